// File: rtl/viterbi_decoder_param_if.sv
// rtl/viterbi_decoder_param_if.sv - symbol-in / decoded-bit-out bundle for the Viterbi decoder
// master drives symbols and flush requests; slave is the decoder.
interface viterbi_decoder_param_if;
  logic       in_valid;
  logic [1:0] in_sym;
  logic       frame_start;
  logic       flush;
  logic       busy;
  logic       out_valid;
  logic       out_bit;
  logic       out_last;

  modport master (
    output in_valid, in_sym, frame_start, flush,
    input  busy, out_valid, out_bit, out_last
  );

  modport slave (
    input  in_valid, in_sym, frame_start, flush,
    output busy, out_valid, out_bit, out_last
  );
endinterface

// File: rtl/viterbi_decoder_param.sv
// rtl/viterbi_decoder_param.sv - parametrised hard-decision rate-1/2 Viterbi decoder
// Register-exchange survivors, per-step metric normalisation, streaming output and flush drain.
module viterbi_decoder_param #(
  parameter int             K        = 3,
  parameter logic [K-1:0]   G0       = 3'b111,
  parameter logic [K-1:0]   G1       = 3'b101,
  parameter int             TB_DEPTH = 15,
  parameter int             PM_W     = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  viterbi_decoder_param_if.slave   s_if
);

  localparam int NS = 1 << (K - 1);
  localparam int SW = K - 1;
  localparam int CW = $clog2(TB_DEPTH + 1);
  localparam int IW = $clog2(TB_DEPTH);
  localparam logic [PM_W-1:0] PM_MAX  = {PM_W{1'b1}};
  localparam logic [PM_W-1:0] PM_INIT = PM_W'(1 << (PM_W - 2));
  localparam logic [CW-1:0]   CNT_MAX = CW'(TB_DEPTH);
  localparam logic [CW-1:0]   PEND_MAX = CW'(TB_DEPTH - 1);

  typedef enum logic {ST_RUN, ST_DRAIN} state_t;

  state_t              r_state;
  logic [PM_W-1:0]     r_pm   [NS];
  logic [TB_DEPTH-1:0] r_hist [NS];
  logic [CW-1:0]       r_cnt;
  logic [SW-1:0]       r_best;
  logic [TB_DEPTH-1:0] r_drain;
  logic [IW-1:0]       r_idx;
  logic                r_busy;
  logic                r_out_valid;
  logic                r_out_bit;
  logic                r_out_last;

  logic [PM_W-1:0]     w_pm_src   [NS];
  logic [TB_DEPTH-1:0] w_hist_src [NS];
  logic [PM_W-1:0]     w_sum0     [NS];
  logic [PM_W-1:0]     w_sum1     [NS];
  logic [PM_W-1:0]     w_pm_acs   [NS];
  logic [PM_W-1:0]     w_pm_new   [NS];
  logic [TB_DEPTH-1:0] w_hist_new [NS];
  logic [PM_W-1:0]     w_pm_min;
  logic [SW-1:0]       w_best_new;

  logic                w_accept;
  logic                w_flush_go;
  logic [CW-1:0]       w_cnt_base;
  logic [CW:0]         w_cnt_inc;
  logic [CW-1:0]       w_cnt_next;
  logic                w_emit;
  logic [CW-1:0]       w_pend;
  logic [IW-1:0]       w_first_idx;

  // Expected {c0,c1} when input u drives the encoder out of state p.
  function automatic logic [1:0] branch_sym(input int p, input logic u);
    logic [K-1:0] r;
    r = {u, p[K-2:0]};
    return {^(r & G0), ^(r & G1)};
  endfunction

  function automatic logic [1:0] hamming(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {x[1] & x[0], x[1] ^ x[0]};
  endfunction

  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a, input logic [1:0] b);
    logic [PM_W:0] s;
    s = {1'b0, a} + {{(PM_W-1){1'b0}}, b};
    return s[PM_W] ? PM_MAX : s[PM_W-1:0];
  endfunction

  assign w_accept    = (r_state == ST_RUN) && s_if.in_valid;
  assign w_flush_go  = (r_state == ST_RUN) && s_if.flush && !s_if.in_valid && (r_cnt != '0);
  assign w_cnt_base  = s_if.frame_start ? '0 : r_cnt;
  assign w_cnt_inc   = {1'b0, w_cnt_base} + 1'b1;
  assign w_emit      = w_accept && (w_cnt_inc >= (CW+1)'(TB_DEPTH));
  assign w_cnt_next  = (w_cnt_inc >= (CW+1)'(TB_DEPTH)) ? CNT_MAX : w_cnt_inc[CW-1:0];
  assign w_pend      = (r_cnt > PEND_MAX) ? PEND_MAX : r_cnt;
  assign w_first_idx = IW'(w_pend - 1'b1);

  // A frame_start symbol runs its ACS on freshly initialised metrics and history.
  always_comb begin
    w_pm_min   = PM_MAX;
    w_best_new = '0;
    for (int n = 0; n < NS; n++) begin
      w_pm_src[n]   = s_if.frame_start ? ((n == 0) ? '0 : PM_INIT) : r_pm[n];
      w_hist_src[n] = s_if.frame_start ? '0 : r_hist[n];
    end
    for (int n = 0; n < NS; n++) begin
      w_sum0[n] = sat_add(w_pm_src[(2*n) % NS],
                          hamming(s_if.in_sym, branch_sym((2*n) % NS, n[K-2])));
      w_sum1[n] = sat_add(w_pm_src[(2*n) % NS + 1],
                          hamming(s_if.in_sym, branch_sym((2*n) % NS + 1, n[K-2])));
      if (w_sum0[n] <= w_sum1[n]) begin
        w_pm_acs[n]   = w_sum0[n];
        w_hist_new[n] = {w_hist_src[(2*n) % NS][TB_DEPTH-2:0], n[K-2]};
      end else begin
        w_pm_acs[n]   = w_sum1[n];
        w_hist_new[n] = {w_hist_src[(2*n) % NS + 1][TB_DEPTH-2:0], n[K-2]};
      end
      if (w_pm_acs[n] < w_pm_min) w_pm_min = w_pm_acs[n];
    end
    // Walking downwards leaves the lowest index holding the minimum as best.
    for (int n = NS - 1; n >= 0; n--) begin
      w_pm_new[n] = w_pm_acs[n] - w_pm_min;
      if (w_pm_acs[n] == w_pm_min) w_best_new = SW'(n);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_cnt       <= '0;
      r_best      <= '0;
      r_drain     <= '0;
      r_idx       <= '0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_bit   <= 1'b0;
      r_out_last  <= 1'b0;
      for (int n = 0; n < NS; n++) begin
        r_pm[n]   <= (n == 0) ? '0 : PM_INIT;
        r_hist[n] <= '0;
      end
    end else begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (w_accept) begin
            for (int n = 0; n < NS; n++) begin
              r_pm[n]   <= w_pm_new[n];
              r_hist[n] <= w_hist_new[n];
            end
            r_cnt  <= w_cnt_next;
            r_best <= w_best_new;
            if (w_emit) begin
              r_out_valid <= 1'b1;
              r_out_bit   <= w_hist_new[w_best_new][TB_DEPTH-1];
            end
          end else if (w_flush_go) begin
            r_state     <= ST_DRAIN;
            r_busy      <= 1'b1;
            r_drain     <= r_hist[r_best];
            r_out_valid <= 1'b1;
            r_out_bit   <= r_hist[r_best][w_first_idx];
            r_out_last  <= (w_first_idx == '0);
            r_idx       <= w_first_idx - 1'b1;
          end
        end
        ST_DRAIN: begin
          if (r_out_last) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_best  <= '0;
            for (int n = 0; n < NS; n++) begin
              r_pm[n]   <= (n == 0) ? '0 : PM_INIT;
              r_hist[n] <= '0;
            end
          end else begin
            r_out_valid <= 1'b1;
            r_out_bit   <= r_drain[r_idx];
            r_out_last  <= (r_idx == '0);
            r_idx       <= r_idx - 1'b1;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign s_if.busy      = r_busy;
  assign s_if.out_valid = r_out_valid;
  assign s_if.out_bit   = r_out_bit;
  assign s_if.out_last  = r_out_last;

endmodule

// File: tb/tb_viterbi_decoder_param.sv
// tb/tb_viterbi_decoder_param.sv - scoreboard bench for viterbi_decoder_param (K=3, 7/5, depth 15)
// Expected decoded bits are the transmitted message bits; timing expectations come from the driver.
module tb_viterbi_decoder_param;
  localparam int K  = 3;
  localparam int TB = 15;
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  typedef struct packed { logic b; logic last; } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  viterbi_decoder_param_if vif ();

  viterbi_decoder_param #(.K(K), .G0(G0), .G1(G1), .TB_DEPTH(TB), .PM_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_if  (vif)
  );

  always #5 clk = ~clk;

  exp_t        q[$];
  int          n_vec    = 0;
  int          n_err    = 0;
  int          n_out    = 0;
  int          exp_outs = 0;
  logic        chk_en   = 1'b0;
  logic        exp_ov   = 1'b0;
  logic        exp_busy = 1'b0;
  logic [K-2:0] enc_st  = '0;
  int          cnt_m    = 0;

  // Monitor: samples 2 time units after each rising edge.
  always @(posedge clk) begin : monitor
    exp_t e;
    #2;
    if (chk_en) begin
      n_vec++;
      if (vif.out_valid !== exp_ov) begin
        n_err++;
        $display("FAIL out_valid_timing: got %b want %b at %0t", vif.out_valid, exp_ov, $time);
      end
      n_vec++;
      if (vif.busy !== exp_busy) begin
        n_err++;
        $display("FAIL busy_timing: got %b want %b at %0t", vif.busy, exp_busy, $time);
      end
    end
    if (vif.out_valid === 1'b1) begin
      n_out++;
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: got bit %b, want no output at %0t", vif.out_bit, $time);
      end else begin
        e = q.pop_front();
        if ({vif.out_bit, vif.out_last} !== {e.b, e.last}) begin
          n_err++;
          $display("FAIL decoded_bit: got bit=%b last=%b want bit=%b last=%b at %0t",
                   vif.out_bit, vif.out_last, e.b, e.last, $time);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  function automatic int pending_bits();
    return (cnt_m < TB - 1) ? cnt_m : TB - 1;
  endfunction

  task automatic reset_model();
    enc_st = '0;
    cnt_m  = 0;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      vif.in_valid    = 1'b0;
      vif.frame_start = 1'b0;
      vif.flush       = 1'b0;
      vif.in_sym      = 2'($urandom_range(0, 3));
      exp_ov   = 1'b0;
      exp_busy = 1'b0;
      @(negedge clk);
    end
  endtask

  // Encodes u from the model state and presents the symbol for one cycle.
  task automatic send(input logic u, input logic fs, input logic [1:0] flip);
    logic [K-1:0] r;
    logic [1:0]   sym;
    exp_t         e;
    if (fs) begin
      for (int i = 0; i < pending_bits(); i++) e = q.pop_back();
      reset_model();
    end
    r      = {u, enc_st};
    sym    = {^(r & G0), ^(r & G1)} ^ flip;
    enc_st = r[K-1:1];
    e.b    = u;
    e.last = 1'b0;
    q.push_back(e);
    cnt_m++;
    vif.in_valid    = 1'b1;
    vif.in_sym      = sym;
    vif.frame_start = fs;
    vif.flush       = 1'b0;
    exp_ov   = (cnt_m >= TB);
    exp_busy = 1'b0;
    if (cnt_m >= TB) exp_outs++;
    @(negedge clk);
    vif.in_valid    = 1'b0;
    vif.frame_start = 1'b0;
  endtask

  task automatic do_flush(input logic junk);
    exp_t e;
    int   p;
    p = pending_bits();
    if (p > 0) begin
      e = q.pop_back();
      e.last = 1'b1;
      q.push_back(e);
    end
    exp_outs += p;
    vif.flush    = 1'b1;
    vif.in_valid = 1'b0;
    exp_ov   = (p > 0);
    exp_busy = (p > 0);
    @(negedge clk);
    vif.flush = 1'b0;
    for (int i = 1; i < p; i++) begin
      vif.in_valid = junk;
      vif.in_sym   = 2'($urandom_range(0, 3));
      exp_ov   = 1'b1;
      exp_busy = 1'b1;
      @(negedge clk);
    end
    vif.in_valid = junk && (p > 0);
    vif.in_sym   = 2'($urandom_range(0, 3));
    exp_ov   = 1'b0;
    exp_busy = 1'b0;
    @(negedge clk);
    vif.in_valid = 1'b0;
    reset_model();
  endtask

  task automatic send_frame(input int len, input logic fs, input logic errs, input int gap_pct);
    logic [1:0] fl;
    for (int i = 0; i < len; i++) begin
      fl = 2'b00;
      if (errs && (i % 50 == 25) && (i < len - 30)) fl = 2'($urandom_range(1, 2));
      send(1'($urandom_range(0, 1)), fs && (i == 0), fl);
      if (int'($urandom_range(0, 99)) < gap_pct) gap(int'($urandom_range(1, 3)));
    end
  endtask

  initial begin : stim
    logic [0:19] msg;
    exp_t        e;
    msg = 20'b1011_0000_0000_0000_0000;
    vif.in_valid    = 1'b0;
    vif.in_sym      = 2'b00;
    vif.frame_start = 1'b0;
    vif.flush       = 1'b0;

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy",      int'(vif.busy),      0);
    chk("reset_out_valid", int'(vif.out_valid), 0);
    chk("reset_out_bit",   int'(vif.out_bit),   0);
    chk("reset_out_last",  int'(vif.out_last),  0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    gap(2);

    // Error-free directed message 1011 + 16 zeros, then flush of 14 bits.
    for (int i = 0; i < 20; i++) send(msg[i], i == 0, 2'b00);
    do_flush(1'b0);
    gap(2);

    // Same stream with the third symbol corrupted from 00 to 10.
    for (int i = 0; i < 20; i++) send(msg[i], 1'b0, (i == 2) ? 2'b10 : 2'b00);
    do_flush(1'b0);
    gap(1);

    // Short frame: four symbols then flush.
    for (int i = 0; i < 4; i++) send(msg[i], 1'b0, 2'b00);
    do_flush(1'b0);

    // Flush with nothing pending.
    do_flush(1'b0);
    gap(1);

    // Back-to-back frames, second tagged frame_start, with gaps and isolated errors.
    send_frame(200, 1'b1, 1'b1, 30);
    send_frame(250, 1'b1, 1'b1, 30);
    do_flush(1'b1);

    for (int f = 0; f < 8; f++) begin
      send_frame(int'($urandom_range(40, 400)), 1'($urandom_range(0, 1)), 1'b1, 20);
      if ($urandom_range(0, 1) == 1) do_flush(1'($urandom_range(0, 1)));
      else gap(int'($urandom_range(0, 2)));
    end
    do_flush(1'b1);

    // Asynchronous reset in the middle of a drain.
    send_frame(40, 1'b0, 1'b0, 0);
    vif.flush = 1'b1;
    exp_ov    = 1'b1;
    exp_busy  = 1'b1;
    @(negedge clk);
    vif.flush = 1'b0;
    repeat (3) @(negedge clk);
    chk_en   = 1'b0;
    exp_outs += 5;
    @(posedge clk);
    #4 rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", int'(vif.out_valid), 0);
    chk("async_reset_busy",      int'(vif.busy),      0);
    chk("async_reset_out_last",  int'(vif.out_last),  0);
    chk("async_reset_out_bit",   int'(vif.out_bit),   0);
    q.delete();
    reset_model();
    @(negedge clk);
    rst_n    = 1'b1;
    exp_ov   = 1'b0;
    exp_busy = 1'b0;
    chk_en   = 1'b1;
    gap(2);
    chk("no_resumed_drain", n_out, exp_outs);

    send_frame(120, 1'b0, 1'b1, 25);
    do_flush(1'b0);
    gap(3);

    chk("output_count", n_out, exp_outs);
    chk("scoreboard_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/viterbi_decoder_param.md
# viterbi_decoder_param

Parametrised hard-decision Viterbi decoder for the rate-1/2 convolutional code produced by the team's encoder. It generalises the fixed K=3, 15-symbol decoder to any constraint length 3..7, any generator pair and any survivor depth. It accepts one 2-bit code symbol per cycle with a valid qualifier and streams decoded bits out through register-exchange survivor memory. It adds frame restart and end-of-frame flush.

## Interface
- K, 3: constraint length, legal range 3..7; NS = 2^(K-1) trellis states.
- G0, 3'b111: generator for in_sym[1], K bits; bit K-1 taps the newest input.
- G1, 3'b101: generator for in_sym[0], K bits.
- TB_DEPTH, 15: survivor history length in bits, legal range 4..64.
- PM_W, 6: path-metric width; must be at least 4.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  in  1  in_sym is valid this cycle; ignored while busy=1.
- in_sym  in  2  received code symbol {c0,c1}.
- frame_start  in  1  qualified by in_valid; restarts the trellis before this symbol is applied.
- flush  in  1  single-cycle request to drain pending bits; honoured only when busy=0 and in_valid=0.
- busy  out  1  flush drain in progress.
- out_valid  out  1  out_bit is valid.
- out_bit  out  1  decoded information bit.
- out_last  out  1  marks the final bit of a flush drain.

## Operation
- Encoder model:
  - State s holds the last K-1 inputs, with the newest input in the MSB.
  - For input u, reg = {u, s}, c0 = ^(reg & G0), c1 = ^(reg & G1), and next state = {u, s[K-2:1]}.
- Branch metric: Hamming distance between in_sym and the expected {c0,c1}, range 0..2.
- ACS for new state n (decided bit u = n[K-2]):
  - Predecessors are p0 = {n[K-3:0],0} and p1 = {n[K-3:0],1}.
  - Select the predecessor with the smaller metric+BM; on a tie, select p0.
  - Survivor update: hist[n] = {hist[p][TB_DEPTH-2:0], u}.
- Metrics:
  - Unsigned, PM_W bits.
  - After each ACS step, subtract the minimum new metric from all states, so the best state is always 0.
  - Any sum exceeding 2^PM_W-1 saturates at that value.
- Initial / frame-restart state:
  - pm[0]=0 and pm[s≠0]=2^(PM_W-2).
  - All hist are 0.
  - The symbol counter cnt is 0; cnt increments on each accepted symbol and saturates at TB_DEPTH.
- Best state: the state with minimum metric, lowest index on a tie, evaluated on the metrics just computed.
- Streaming output:
  - When an accepted symbol brings the frame's symbol count (cnt+1) to at least TB_DEPTH, the block emits hist[best][TB_DEPTH-1] of the updated metrics.
  - This is the information bit for symbol index n-TB_DEPTH+1, where n is the 0-based index of the accepted symbol.
- frame_start with in_valid: reinitialise metrics, history and cnt first, then process the symbol as index 0.
- FSM states:
  - RUN → DRAIN on an honoured flush with cnt > 0. In DRAIN, busy=1.
  - Pending count P = min(cnt, TB_DEPTH-1).
  - On entry, latch the best state's history.
  - Emit bits from index P-1 down to 0, one per cycle; out_last=1 with index 0.
  - After the last bit, reinitialise the frame and return to RUN.
  - A flush with cnt=0 is accepted and does nothing: no output, busy stays 0.
- in_valid while busy=1: the symbol is dropped and must not alter any state.

## Timing
- Reset values: busy=0, out_valid=0, out_bit=0, out_last=0; metrics, history and cnt at their initial values; FSM in RUN.
- Streaming latency:
  - out_valid/out_bit are registered and appear the cycle after the clock edge that accepts the symbol.
  - The first output follows the TB_DEPTH-th symbol of the frame.
- Throughput: one symbol per cycle; in_valid gaps produce matching out_valid gaps.
- Flush:
  - busy rises the cycle after flush is sampled and stays high for exactly P cycles.
  - The first drained bit appears in that same first busy cycle.
  - busy falls in the cycle after out_last.
  - A new symbol may be accepted in the cycle busy is low again.
- Asynchronous reset mid-frame or mid-drain: all outputs are cleared immediately; no partial drain resumes.

## Test plan
- Error-free, K=3, G 7/5, TB_DEPTH=15:
  - Stimulus: message 1,0,1,1 followed by 16 zeros, i.e. symbols 11,10,00,01,01,11,00…
  - Response: first out_valid one cycle after the 15th symbol; bits 1,0,1,1,0,0 in order; then flush drains 14 bits (the remaining zeros), with out_last on the 14th.
- Single error: same stream with symbol 3 changed from 00 to 10. Decoded output must be bit-identical to the error-free case.
- Short-frame flush: 4 symbols 11,10,00,01, then flush. Response: busy high for 4 cycles, outputs 1,0,1,1, out_last with the final 1.
- Frame restart and gaps: two back-to-back frames, the second tagged with frame_start, with random in_valid gaps.
  - The second frame decodes independently.
  - out_valid count equals accepted symbols minus 14 per frame.
- Long stream, K=7, G 7'o171/7'o133, TB_DEPTH=48, PM_W=8: 10,000 random bits with one bit error every 50 symbols. Response: zero decoded errors and metric 0 present every step.
- Reset and busy:
  - rst_n pulsed low during a drain: outputs go to 0 asynchronously and the next frame decodes correctly.
  - in_valid asserted while busy: those symbols are ignored.
